// File: rtl/dirty_sweep_engine.sv
// dirty_sweep_engine
//
// Walks every set of a dual-port flip-flop metadata array through port 0 and
// offers each set with any dirty bit set as an evict record. Once a record is
// accepted, the dirty bits of that set are cleared with a port-0 write. Port 1
// belongs to the cache datapath and is only snooped here. If a cache write
// touches the current set while the engine is between reading it and clearing
// it, the clear is skipped and the set is read again. This means a concurrent
// update is never overwritten, and the two ports never write the same address
// in the same cycle.
//
// Ports
//   clk0, rst0              clock, synchronous active-high reset
//   start                   one-cycle sweep request (only honoured when idle)
//   busy, done              sweep in progress / one-cycle completion pulse
//   arr_csb0, arr_web0      port-0 select and write enable (active low)
//   arr_addr0, arr_din0     port-0 address and write data
//   arr_dout0               port-0 read data, valid the cycle after a read
//   snoop_csb1, snoop_web1  copies of the cache's port-1 select / write enable
//   snoop_addr1             copy of the cache's port-1 address
//   evict_valid/ready       record handshake
//   evict_index, evict_data set index and entry value of the record
module dirty_sweep_engine #(
  parameter int               S_INDEX    = 4,
  parameter int               WIDTH      = 1,
  parameter logic [WIDTH-1:0] DIRTY_MASK = '1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  output logic [WIDTH-1:0]   arr_din0,
  input  logic [WIDTH-1:0]   arr_dout0,
  input  logic               snoop_csb1,
  input  logic               snoop_web1,
  input  logic [S_INDEX-1:0] snoop_addr1,
  output logic               evict_valid,
  input  logic               evict_ready,
  output logic [S_INDEX-1:0] evict_index,
  output logic [WIDTH-1:0]   evict_data
);

  localparam int                 NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] LAST_IDX = S_INDEX'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_EMIT,
    ST_CLEAR,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [S_INDEX-1:0]   r_idx;
  logic                 r_conflict;
  logic [S_INDEX-1:0]   r_evict_index;
  logic [WIDTH-1:0]     r_evict_data;

  state_t               w_state_next;
  logic [S_INDEX-1:0]   w_idx_next;
  logic                 w_conflict_next;
  logic [S_INDEX-1:0]   w_evict_index_next;
  logic [WIDTH-1:0]     w_evict_data_next;

  logic                 w_snoop_hit;
  logic                 w_is_dirty;
  logic                 w_last;

  // Cache write to the set currently being processed.
  assign w_snoop_hit = !snoop_csb1 && !snoop_web1 && (snoop_addr1 == r_idx);
  assign w_is_dirty  = (arr_dout0 & DIRTY_MASK) != '0;
  assign w_last      = (r_idx == LAST_IDX);

  // Status and record outputs decode from state or come straight from registers.
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign evict_valid = (r_state == ST_EMIT);
  assign evict_index = r_evict_index;
  assign evict_data  = r_evict_data;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_conflict    <= 1'b0;
      r_evict_index <= '0;
      r_evict_data  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_conflict    <= w_conflict_next;
      r_evict_index <= w_evict_index_next;
      r_evict_data  <= w_evict_data_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_conflict_next    = r_conflict;
    w_evict_index_next = r_evict_index;
    w_evict_data_next  = r_evict_data;
    arr_csb0           = 1'b1;
    arr_web0           = 1'b1;
    arr_addr0          = r_idx;
    arr_din0           = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_idx_next   = '0;
          w_state_next = ST_READ;
        end
      end

      ST_READ: begin
        arr_csb0     = 1'b0;
        w_state_next = ST_CHECK;
        if (w_snoop_hit) w_conflict_next = 1'b1;
      end

      ST_CHECK: begin
        if (w_is_dirty) begin
          w_evict_index_next = r_idx;
          w_evict_data_next  = arr_dout0;
          w_state_next       = ST_EMIT;
          if (w_snoop_hit) w_conflict_next = 1'b1;
        end else begin
          // Advance: a clean set leaves nothing pending, so drop any conflict.
          w_conflict_next = 1'b0;
          if (w_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_idx_next   = r_idx + S_INDEX'(1);
            w_state_next = ST_READ;
          end
        end
      end

      ST_EMIT: begin
        if (w_snoop_hit) w_conflict_next = 1'b1;
        if (evict_ready) w_state_next = ST_CLEAR;
      end

      ST_CLEAR: begin
        w_conflict_next = 1'b0;
        // The snoop term is the only combinational input-to-port-0 path: a cache
        // write landing in this very cycle must also block the clear.
        if (r_conflict || w_snoop_hit) begin
          w_state_next = ST_READ;
        end else begin
          arr_csb0 = 1'b0;
          arr_web0 = 1'b0;
          arr_din0 = r_evict_data & ~DIRTY_MASK;
          if (w_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_idx_next   = r_idx + S_INDEX'(1);
            w_state_next = ST_READ;
          end
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dirty_sweep_engine.sv
// Directed bench for dirty_sweep_engine (S_INDEX=4, WIDTH=2, DIRTY_MASK=2'b10).
// The bench models the dual-port flip-flop array. Port 0 is driven by the DUT.
// Port 1 is driven by the bench, and the same signals feed the DUT's snoop inputs.
module tb_dirty_sweep_engine;

  localparam int S_INDEX = 4;
  localparam int WIDTH   = 2;

  logic               clk0 = 1'b0;
  logic               rst0 = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic               done;
  logic               arr_csb0;
  logic               arr_web0;
  logic [S_INDEX-1:0] arr_addr0;
  logic [WIDTH-1:0]   arr_din0;
  logic [WIDTH-1:0]   arr_dout0 = '0;
  logic               snoop_csb1 = 1'b1;
  logic               snoop_web1 = 1'b1;
  logic [S_INDEX-1:0] snoop_addr1 = '0;
  logic [WIDTH-1:0]   snoop_din1 = '0;
  logic               evict_valid;
  logic               evict_ready = 1'b0;
  logic [S_INDEX-1:0] evict_index;
  logic [WIDTH-1:0]   evict_data;

  int checks   = 0;
  int failures = 0;

  // State written only by the monitor process.
  logic [WIDTH-1:0]   mem [16];
  logic [S_INDEX-1:0] rec_idx [64];
  logic [WIDTH-1:0]   rec_data [64];
  int rec_cnt     = 0;
  int clr_cnt     = 0;
  int done_cnt    = 0;
  int collide_cnt = 0;

  always #5 clk0 = ~clk0;

  dirty_sweep_engine #(
    .S_INDEX   (S_INDEX),
    .WIDTH     (WIDTH),
    .DIRTY_MASK(2'b10)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .arr_csb0   (arr_csb0),
    .arr_web0   (arr_web0),
    .arr_addr0  (arr_addr0),
    .arr_din0   (arr_din0),
    .arr_dout0  (arr_dout0),
    .snoop_csb1 (snoop_csb1),
    .snoop_web1 (snoop_web1),
    .snoop_addr1(snoop_addr1),
    .evict_valid(evict_valid),
    .evict_ready(evict_ready),
    .evict_index(evict_index),
    .evict_data (evict_data)
  );

  // Array model and transaction monitor.
  always @(posedge clk0) begin
    if (!arr_csb0 && arr_web0) arr_dout0 <= mem[arr_addr0];
    if (!arr_csb0 && !arr_web0) begin
      mem[arr_addr0] <= arr_din0;
      clr_cnt <= clr_cnt + 1;
      $display("clear write set=%0d data=%b", arr_addr0, arr_din0);
    end
    if (!snoop_csb1 && !snoop_web1) mem[snoop_addr1] <= snoop_din1;
    if (!arr_csb0 && !arr_web0 && !snoop_csb1 && !snoop_web1 && arr_addr0 == snoop_addr1)
      collide_cnt <= collide_cnt + 1;
    if (!rst0 && evict_valid && evict_ready) begin
      rec_idx[rec_cnt]  <= evict_index;
      rec_data[rec_cnt] <= evict_data;
      rec_cnt <= rec_cnt + 1;
      $display("evict record set=%0d data=%b", evict_index, evict_data);
    end
    if (!rst0 && done) done_cnt <= done_cnt + 1;
  end

  task automatic write_p1(input logic [S_INDEX-1:0] a, input logic [WIDTH-1:0] d);
    snoop_csb1 = 1'b0; snoop_web1 = 1'b0; snoop_addr1 = a; snoop_din1 = d;
    @(negedge clk0);
    snoop_csb1 = 1'b1; snoop_web1 = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk0);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string what);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", what, done, n);
    end
    @(negedge clk0);
  endtask

  task automatic wait_valid(input int budget, input string what);
    int n = 0;
    while (evict_valid !== 1'b1 && n < budget) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (evict_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_timeout: evict_valid=%b after %0d cycles, required 1", what, evict_valid, n);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    repeat (3) @(negedge clk0);
    checks++;
    if ({busy, done, arr_csb0, arr_web0, arr_addr0, arr_din0, evict_valid, evict_index, evict_data}
        !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b csb0=%b web0=%b addr0=%0d din0=%b valid=%b idx=%0d data=%b",
               busy, done, arr_csb0, arr_web0, arr_addr0, arr_din0, evict_valid, evict_index, evict_data);
    end
    rst0 = 1'b0;
    @(negedge clk0);
    for (int i = 0; i < 16; i++) write_p1(4'(i), 2'b00);
    $display("reset checked, array zeroed");
  endtask

  task automatic test_all_clean();
    int base_done = done_cnt;
    int base_rec  = rec_cnt;
    evict_ready = 1'b0;
    pulse_start();
    for (int n = 1; n <= 36; n++) begin
      checks++;
      if ({busy, done, evict_valid} !== {(n <= 33), (n == 33), 1'b0}) begin
        failures++;
        $display("FAIL clean_cycle%0d: busy/done/valid=%b%b%b, required %b%b0",
                 n, busy, done, evict_valid, n <= 33, n == 33);
      end
      @(negedge clk0);
    end
    checks++;
    if (done_cnt - base_done != 1 || rec_cnt != base_rec) begin
      failures++;
      $display("FAIL clean_counts: done pulses=%0d records=%0d, required 1 and 0",
               done_cnt - base_done, rec_cnt - base_rec);
    end
    $display("all-clean sweep finished");
  endtask

  task automatic test_two_dirty();
    int base_rec = rec_cnt;
    int base_clr = clr_cnt;
    int bad = 0;
    write_p1(4'd3, 2'b11);
    write_p1(4'd12, 2'b11);
    evict_ready = 1'b1;
    pulse_start();
    wait_done(200, "two_dirty");
    checks++;
    if (rec_cnt - base_rec != 2 || clr_cnt - base_clr != 2) begin
      failures++;
      $display("FAIL two_dirty_counts: records=%0d clears=%0d, required 2 and 2",
               rec_cnt - base_rec, clr_cnt - base_clr);
    end else begin
      checks++;
      if ({rec_idx[base_rec], rec_data[base_rec], rec_idx[base_rec+1], rec_data[base_rec+1]}
          !== {4'd3, 2'b11, 4'd12, 2'b11}) begin
        failures++;
        $display("FAIL two_dirty_records: (%0d,%b) (%0d,%b), required (3,11) (12,11)",
                 rec_idx[base_rec], rec_data[base_rec], rec_idx[base_rec+1], rec_data[base_rec+1]);
      end
    end
    for (int i = 0; i < 16; i++)
      if (mem[i] !== ((i == 3 || i == 12) ? 2'b01 : 2'b00)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL two_dirty_array: %0d sets wrong (set3=%b set12=%b), required 01/01 and others 00",
               bad, mem[3], mem[12]);
    end
    evict_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int base_clr = clr_cnt;
    write_p1(4'd5, 2'b10);
    evict_ready = 1'b0;
    pulse_start();
    wait_valid(100, "backpressure");
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if ({evict_valid, evict_index, evict_data} !== {1'b1, 4'd5, 2'b10}) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b idx=%0d data=%b, required 1/5/10",
                 k, evict_valid, evict_index, evict_data);
      end
      if (k == 6) evict_ready = 1'b1;
      @(negedge clk0);
    end
    evict_ready = 1'b0;
    checks++;
    if ({evict_valid, arr_csb0, arr_web0, arr_addr0, arr_din0} !== {1'b0, 1'b0, 1'b0, 4'd5, 2'b00}) begin
      failures++;
      $display("FAIL clear_after_accept: valid=%b csb0=%b web0=%b addr0=%0d din0=%b, required 0/0/0/5/00",
               evict_valid, arr_csb0, arr_web0, arr_addr0, arr_din0);
    end
    wait_done(200, "backpressure");
    checks++;
    if (clr_cnt - base_clr != 1 || mem[5] !== 2'b00) begin
      failures++;
      $display("FAIL backpressure_clear: clears=%0d set5=%b, required 1 and 00", clr_cnt - base_clr, mem[5]);
    end
  endtask

  task automatic test_snoop_emit();
    int base_rec = rec_cnt;
    int base_clr = clr_cnt;
    write_p1(4'd7, 2'b10);
    evict_ready = 1'b0;
    pulse_start();
    wait_valid(100, "snoop_emit");
    write_p1(4'd7, 2'b11);
    evict_ready = 1'b1;
    @(negedge clk0);
    checks++;
    if ({arr_csb0, arr_web0} !== 2'b11) begin
      failures++;
      $display("FAIL snoop_emit_suppress: csb0=%b web0=%b in CLEAR, required 1/1", arr_csb0, arr_web0);
    end
    wait_done(200, "snoop_emit");
    evict_ready = 1'b0;
    checks++;
    if (rec_cnt - base_rec != 2 || clr_cnt - base_clr != 1) begin
      failures++;
      $display("FAIL snoop_emit_counts: records=%0d clears=%0d, required 2 and 1",
               rec_cnt - base_rec, clr_cnt - base_clr);
    end else begin
      checks++;
      if ({rec_idx[base_rec], rec_data[base_rec], rec_idx[base_rec+1], rec_data[base_rec+1]}
          !== {4'd7, 2'b10, 4'd7, 2'b11}) begin
        failures++;
        $display("FAIL snoop_emit_records: (%0d,%b) (%0d,%b), required (7,10) (7,11)",
                 rec_idx[base_rec], rec_data[base_rec], rec_idx[base_rec+1], rec_data[base_rec+1]);
      end
    end
    checks++;
    if (mem[7] !== 2'b01) begin
      failures++;
      $display("FAIL snoop_emit_final: set7=%b, required 01", mem[7]);
    end
  endtask

  task automatic test_snoop_clear();
    int base_rec = rec_cnt;
    int base_clr = clr_cnt;
    write_p1(4'd8, 2'b10);
    evict_ready = 1'b1;
    pulse_start();
    wait_valid(100, "snoop_clear");
    @(negedge clk0);
    snoop_csb1 = 1'b0; snoop_web1 = 1'b0; snoop_addr1 = 4'd8; snoop_din1 = 2'b10;
    #1;
    checks++;
    if ({arr_csb0, arr_web0} !== 2'b11) begin
      failures++;
      $display("FAIL snoop_clear_suppress: csb0=%b web0=%b with same-cycle snoop, required 1/1",
               arr_csb0, arr_web0);
    end
    @(negedge clk0);
    snoop_csb1 = 1'b1; snoop_web1 = 1'b1;
    wait_done(200, "snoop_clear");
    evict_ready = 1'b0;
    checks++;
    if (rec_cnt - base_rec != 2 || clr_cnt - base_clr != 1 || mem[8] !== 2'b00) begin
      failures++;
      $display("FAIL snoop_clear_result: records=%0d clears=%0d set8=%b, required 2, 1, 00",
               rec_cnt - base_rec, clr_cnt - base_clr, mem[8]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int base_done;
    int base_rec;
    write_p1(4'd9, 2'b10);
    evict_ready = 1'b0;
    pulse_start();
    wait_valid(100, "reset_mid");
    checks++;
    if (evict_index !== 4'd9) begin
      failures++;
      $display("FAIL reset_mid_emit: idx=%0d, required 9", evict_index);
    end
    base_done = done_cnt;
    base_rec  = rec_cnt;
    rst0 = 1'b1;
    @(negedge clk0);
    rst0 = 1'b0;
    checks++;
    if ({busy, evict_valid, arr_csb0, evict_index, evict_data} !== {1'b0, 1'b0, 1'b1, 4'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid_state: busy=%b valid=%b csb0=%b idx=%0d data=%b, required 0/0/1/0/00",
               busy, evict_valid, arr_csb0, evict_index, evict_data);
    end
    repeat (3) @(negedge clk0);
    checks++;
    if (busy !== 1'b0 || done_cnt != base_done) begin
      failures++;
      $display("FAIL reset_mid_idle: busy=%b done pulses=%0d, required 0 and 0", busy, done_cnt - base_done);
    end
    evict_ready = 1'b1;
    pulse_start();
    checks++;
    if ({arr_csb0, arr_web0, arr_addr0} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL resweep_first_read: csb0=%b web0=%b addr0=%0d, required 0/1/0", arr_csb0, arr_web0, arr_addr0);
    end
    wait_done(200, "reset_mid");
    evict_ready = 1'b0;
    checks++;
    if (rec_cnt - base_rec != 1 || mem[9] !== 2'b00) begin
      failures++;
      $display("FAIL resweep_result: records=%0d set9=%b, required 1 and 00", rec_cnt - base_rec, mem[9]);
    end else begin
      checks++;
      if ({rec_idx[base_rec], rec_data[base_rec]} !== {4'd9, 2'b10}) begin
        failures++;
        $display("FAIL resweep_record: (%0d,%b), required (9,10)", rec_idx[base_rec], rec_data[base_rec]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base_done = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk0);
    pulse_start();
    wait_done(200, "back_to_back");
    repeat (40) @(negedge clk0);
    checks++;
    if (done_cnt - base_done != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy: done pulses=%0d busy=%b, required 1 and 0", done_cnt - base_done, busy);
    end
    checks++;
    if (collide_cnt != 0) begin
      failures++;
      $display("FAIL port_collision: %0d same-address dual writes, required 0", collide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_all_clean();
    test_two_dirty();
    test_backpressure();
    test_snoop_emit();
    test_snoop_clear();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
